// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and load results through an in-order queue
// onto the single register file write port, publishing a pending-write mask.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     elk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     ld_ready,
  output logic                     wr_en,
  output logic [4:0]               wr_addr,
  output logic [31:0]              wr_data,
  output logic [31:0]              pend_mask,
  output logic                     r0_drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR = CW'(DEPTH - 1);

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d, r0_drop_q, r0_drop_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          alu_hs, ld_hs, alu_push, ld_push, pop;

  always_comb begin
    alu_ready = count_q != FULL;
    ld_ready  = (count_q < NEAR) | ((count_q == NEAR) & ~alu_valid);
    alu_hs    = alu_valid & alu_ready & ~flush;
    ld_hs     = ld_valid & ld_ready & ~flush;
    alu_push  = alu_hs & (alu_addr != 5'd0);
    ld_push   = ld_hs & (ld_addr != 5'd0);
    pop       = (count_q != '0) & ~flush;
    addr_d    = addr_q;
    data_d    = data_q;
    if (alu_push) begin
      addr_d[wp_q] = alu_addr;
      data_d[wp_q] = alu_data;
    end
    // the load lands behind the ALU entry when both are accepted together
    if (ld_push) begin
      addr_d[wp_q + PW'(alu_push)] = ld_addr;
      data_d[wp_q + PW'(alu_push)] = ld_data;
    end
    wp_d      = flush ? '0 : wp_q + PW'(alu_push) + PW'(ld_push);
    rp_d      = flush ? '0 : rp_q + PW'(pop);
    count_d   = flush ? '0 : count_q + CW'(alu_push) + CW'(ld_push) - CW'(pop);
    wr_en_d   = pop;
    wr_addr_d = pop ? addr_q[rp_q] : wr_addr_q;
    wr_data_d = pop ? data_q[rp_q] : wr_data_q;
    r0_drop_d = (alu_hs & (alu_addr == 5'd0)) | (ld_hs & (ld_addr == 5'd0));
    pend_mask = wr_en_q ? 32'b1 << wr_addr_q : '0;
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) < count_q) pend_mask |= 32'b1 << addr_q[rp_q + PW'(k)];
  end

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
      rp_q      <= '0;
      wp_q      <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      r0_drop_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      r0_drop_q <= r0_drop_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign r0_drop = r0_drop_q;
  assign count   = count_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vector table plus hand-written reset and
// full-queue sequences (the latter on a DEPTH=2 instance where full is reachable).
module tb_regfile_writeback;
  logic        elk = 1'b0;
  logic        nrst, flush, alu_valid, ld_valid;
  logic [4:0]  alu_addr, ld_addr;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, wr_en, r0_drop;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, pend_mask;
  logic [2:0]  count;

  logic        b_flush, b_av, b_lv, b_ar, b_lr, b_we, b_rd;
  logic [4:0]  b_aa, b_la, b_wa;
  logic [31:0] b_ad, b_ld, b_wd, b_pm;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 elk = ~elk;

  regfile_writeback #(.DEPTH(4)) dut (
    .elk(elk), .nrst(nrst), .flush(flush),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_mask(pend_mask), .r0_drop(r0_drop), .count(count)
  );

  regfile_writeback #(.DEPTH(2)) dut2 (
    .elk(elk), .nrst(nrst), .flush(b_flush),
    .alu_valid(b_av), .alu_addr(b_aa), .alu_data(b_ad), .alu_ready(b_ar),
    .ld_valid(b_lv), .ld_addr(b_la), .ld_data(b_ld), .ld_ready(b_lr),
    .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
    .pend_mask(b_pm), .r0_drop(b_rd), .count(b_cnt)
  );

  typedef struct {
    logic        fl, av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ldd;
    logic        ar, lr, we;
    logic [4:0]  wa;
    logic [31:0] wd, pm;
    logic        rd;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic chk_all(input string t, input logic ar, input logic lr, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pm,
                         input logic rd, input logic [2:0] cnt);
    chk({t, " alu_ready"}, 32'(alu_ready), 32'(ar));
    chk({t, " ld_ready"}, 32'(ld_ready), 32'(lr));
    chk({t, " wr_en"}, 32'(wr_en), 32'(we));
    chk({t, " wr_addr"}, 32'(wr_addr), 32'(wa));
    chk({t, " wr_data"}, wr_data, wd);
    chk({t, " pend_mask"}, pend_mask, pm);
    chk({t, " r0_drop"}, 32'(r0_drop), 32'(rd));
    chk({t, " count"}, 32'(count), 32'(cnt));
  endtask

  task automatic add(input logic fl, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                     input logic ar, input logic lr, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [31:0] pm, input logic rd,
                     input logic [2:0] cnt);
    vec_t v;
    v = '{fl, av, aa, ad, lv, la, ldd, ar, lr, we, wa, wd, pm, rd, cnt};
    vq.push_back(v);
  endtask

  task automatic idle(input logic ar, input logic lr, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] pm, input logic rd,
                      input logic [2:0] cnt);
    add(0, 0, 0, 0, 0, 0, 0, ar, lr, we, wa, wd, pm, rd, cnt);
  endtask

  task automatic drive(input logic fl, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ldd);
    flush = fl; alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
  endtask

  initial begin
    b_flush = 0; b_av = 0; b_aa = 0; b_ad = 0; b_lv = 0; b_la = 0; b_ld = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    nrst = 1'b0;
    // reset held for three cycles with random stimulus
    for (int c = 0; c < 3; c++) begin
      drive(1'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      @(negedge elk);
      chk_all($sformatf("reset%0d", c), 1, 1, 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    nrst = 1'b1;
    @(posedge elk); #1;

    idle(1, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 1, 0, 0, 0, 32'h20, 0, 1);
    idle(1, 1, 1, 5, 32'hDEADBEEF, 32'h20, 0, 0);
    idle(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0);
    add(0, 1, 3, 32'h1, 1, 3, 32'h2, 1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0);
    idle(1, 1, 0, 5, 32'hDEADBEEF, 32'h8, 0, 2);
    idle(1, 1, 1, 3, 32'h1, 32'h8, 0, 1);
    idle(1, 1, 1, 3, 32'h2, 32'h8, 0, 0);
    add(0, 1, 0, 32'h55, 1, 7, 32'h77, 1, 1, 0, 3, 32'h2, 0, 0, 0);
    idle(1, 1, 0, 3, 32'h2, 32'h80, 1, 1);
    idle(1, 1, 1, 7, 32'h77, 32'h80, 0, 0);
    add(0, 1, 0, 32'h1, 1, 0, 32'h2, 1, 1, 0, 7, 32'h77, 0, 0, 0);
    idle(1, 1, 0, 7, 32'h77, 0, 1, 0);
    idle(1, 1, 0, 7, 32'h77, 0, 0, 0);
    // both sources every cycle; the load is starved once count reaches 3
    add(0, 1, 1, 32'hA0, 1, 2, 32'hB0, 1, 1, 0, 7, 32'h77, 0, 0, 0);
    add(0, 1, 3, 32'hA1, 1, 4, 32'hB1, 1, 1, 0, 7, 32'h77, 32'h6, 0, 2);
    add(0, 1, 5, 32'hA2, 1, 6, 32'hB2, 1, 0, 1, 1, 32'hA0, 32'h1E, 0, 3);
    add(0, 1, 7, 32'hA3, 1, 6, 32'hB2, 1, 0, 1, 2, 32'hB0, 32'h3C, 0, 3);
    add(0, 1, 8, 32'hA4, 1, 6, 32'hB2, 1, 0, 1, 3, 32'hA1, 32'hB8, 0, 3);
    add(0, 1, 9, 32'hA5, 1, 6, 32'hB2, 1, 0, 1, 4, 32'hB1, 32'h1B0, 0, 3);
    idle(1, 1, 1, 5, 32'hA2, 32'h3A0, 0, 3);
    idle(1, 1, 1, 7, 32'hA3, 32'h380, 0, 2);
    idle(1, 1, 1, 8, 32'hA4, 32'h300, 0, 1);
    idle(1, 1, 1, 9, 32'hA5, 32'h200, 0, 0);
    idle(1, 1, 0, 9, 32'hA5, 0, 0, 0);
    add(0, 1, 10, 32'hC0, 1, 11, 32'hC1, 1, 1, 0, 9, 32'hA5, 0, 0, 0);
    add(0, 1, 12, 32'hC2, 1, 13, 32'hC3, 1, 1, 0, 9, 32'hA5, 32'hC00, 0, 2);
    add(1, 1, 14, 32'hC4, 0, 0, 0, 1, 0, 1, 10, 32'hC0, 32'h3C00, 0, 3);
    idle(1, 1, 0, 10, 32'hC0, 0, 0, 0);
    idle(1, 1, 0, 10, 32'hC0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].av, vq[i].aa, vq[i].ad, vq[i].lv, vq[i].la, vq[i].ldd);
      @(negedge elk);
      chk_all($sformatf("v%0d", i), vq[i].ar, vq[i].lr, vq[i].we, vq[i].wa, vq[i].wd,
              vq[i].pm, vq[i].rd, vq[i].cnt);
      @(posedge elk); #1;
    end

    // refill, then assert reset between edges
    drive(0, 1, 15, 32'hD0, 1, 16, 32'hD1);
    @(posedge elk); #1;
    drive(0, 1, 17, 32'hD2, 0, 0, 0);
    @(posedge elk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("refill count", 32'(count), 32'd2);
    chk("refill wr_en", 32'(wr_en), 32'd1);
    #2 nrst = 1'b0;
    #1 chk_all("async_rst", 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge elk);
    nrst = 1'b1;
    @(posedge elk); #1;
    chk("post_rst wr_en a", 32'(wr_en), 32'd0);
    @(posedge elk); #1;
    chk("post_rst wr_en b", 32'(wr_en), 32'd0);
    chk("post_rst count", 32'(count), 32'd0);

    // DEPTH=2 instance: reach full, accept-while-full is refused, pop still proceeds
    b_av = 1; b_aa = 1; b_ad = 32'h11; b_lv = 1; b_la = 2; b_ld = 32'h22;
    @(negedge elk);
    chk("full0 alu_ready", 32'(b_ar), 32'd1);
    chk("full0 ld_ready", 32'(b_lr), 32'd1);
    @(posedge elk); #1;
    b_aa = 3; b_ad = 32'h33; b_la = 4; b_ld = 32'h44;
    @(negedge elk);
    chk("full1 count", 32'(b_cnt), 32'd2);
    chk("full1 alu_ready", 32'(b_ar), 32'd0);
    chk("full1 ld_ready", 32'(b_lr), 32'd0);
    chk("full1 pend_mask", b_pm, 32'h6);
    @(posedge elk); #1;
    b_lv = 0;
    @(negedge elk);
    chk("full2 count", 32'(b_cnt), 32'd1);
    chk("full2 alu_ready", 32'(b_ar), 32'd1);
    chk("full2 ld_ready", 32'(b_lr), 32'd0);
    chk("full2 wr", {b_we, 26'd0, b_wa}, {1'b1, 26'd0, 5'd1});
    chk("full2 wr_data", b_wd, 32'h11);
    @(posedge elk); #1;
    b_av = 0;
    @(negedge elk);
    chk("full3 wr", {b_we, 26'd0, b_wa}, {1'b1, 26'd0, 5'd2});
    chk("full3 wr_data", b_wd, 32'h22);
    chk("full3 pend_mask", b_pm, 32'hC);
    @(posedge elk); #1;
    @(negedge elk);
    chk("full4 wr", {b_we, 26'd0, b_wa}, {1'b1, 26'd0, 5'd3});
    chk("full4 wr_data", b_wd, 32'h33);
    chk("full4 count", 32'(b_cnt), 32'd0);
    @(posedge elk); #1;
    @(negedge elk);
    chk("full5 wr_en", 32'(b_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
